// File: rtl/gpmc_pkg.sv
// gpmc_pkg: shared types for the GPMC multiplexed-bus SRAM target.
// Holds the FSM state encoding and the read-latency limit.
package gpmc_pkg;

   localparam int RD_LAT_MAX = 7;
   localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      RD_WAIT,
      RD_BURST,
      WR_BURST
   } state_e;

endpackage

// File: rtl/gpmc_sram_mem.sv
// gpmc_sram_mem: single-port SRAM, synchronous read, per-byte writes.
// Contents have no reset.
module gpmc_sram_mem #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
) (
   input  logic                clk_i,
   input  logic                we_i,
   input  logic [DATA_W/8-1:0] be_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   output logic [DATA_W-1:0]   rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (be_i[b]) begin
               mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/gpmc_mux_sram.sv
// gpmc_mux_sram: GPMC multiplexed address/data SRAM target with bursts.
// Define GPMC_BYTE_LANE_EN to honour GPMC_BEN on writes.
module gpmc_mux_sram
   import gpmc_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 2
) (
   input  logic                CLK,
   input  logic                RST_N,
   inout  wire  [DATA_W-1:0]   GPMC_AD,
   input  logic                GPMC_CSN,
   input  logic                GPMC_ADVN,
   input  logic                GPMC_OEN,
   input  logic                GPMC_WEN,
   input  logic [DATA_W/8-1:0] GPMC_BEN,
   output logic                GPMC_WAIT,
   output logic                ERR
);

   localparam int BW = DATA_W / 8;
   localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(RD_LAT - 1);

   logic              csn_q, advn_q, oen_q, wen_q;
   logic [BW-1:0]     ben_q;
   logic [DATA_W-1:0] ad_q;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wait_q, wait_d;
   logic              err_q, err_d;
   logic              wr_en;

   logic [BW-1:0]     mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] rdata;
   logic              rd_drive;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         csn_q  <= 1'b1;
         advn_q <= 1'b1;
         oen_q  <= 1'b1;
         wen_q  <= 1'b1;
         ben_q  <= '1;
         ad_q   <= '0;
      end else begin
         csn_q  <= GPMC_CSN;
         advn_q <= GPMC_ADVN;
         oen_q  <= GPMC_OEN;
         wen_q  <= GPMC_WEN;
         ben_q  <= GPMC_BEN;
         ad_q   <= GPMC_AD;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      wr_en   = 1'b0;
      if (csn_q) begin
         state_d = IDLE;
      end else if (!oen_q && !wen_q) begin
         state_d = IDLE;
         err_d   = 1'b1;
      end else if (!advn_q) begin
         state_d = ADDR;
         addr_d  = ad_q[ADDR_W-1:0];
      end else begin
         unique case (state_q)
            IDLE: ;
            ADDR: begin
               if (!oen_q) begin
                  state_d = RD_WAIT;
                  cnt_d   = LAT_LD;
               end else if (!wen_q) begin
                  state_d = WR_BURST;
                  wr_en   = 1'b1;
                  addr_d  = addr_q + 1'b1;
               end
            end
            RD_WAIT: begin
               if (cnt_q == '0) state_d = RD_BURST;
               else             cnt_d   = cnt_q - 1'b1;
            end
            RD_BURST: begin
               if (!oen_q) addr_d = addr_q + 1'b1;
            end
            WR_BURST: begin
               if (!wen_q) begin
                  wr_en  = 1'b1;
                  addr_d = addr_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      wait_d = (state_d == RD_WAIT);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         wait_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

`ifdef GPMC_BYTE_LANE_EN
   assign mem_be = ~ben_q;
`else
   // BEN is sampled but every lane is written regardless
   assign mem_be = ben_q | ~ben_q;
`endif

   // Read side prefetches the next address so data meets the burst
   assign mem_addr = wr_en ? addr_q : addr_d;

   gpmc_sram_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk_i   (CLK),
      .we_i    (wr_en),
      .be_i    (mem_be),
      .addr_i  (mem_addr),
      .wdata_i (ad_q),
      .rdata_o (rdata)
   );

   assign rd_drive  = (state_q == RD_BURST) && !csn_q && !oen_q;
   assign GPMC_AD   = rd_drive ? rdata : {DATA_W{1'bz}};
   assign GPMC_WAIT = wait_q;
   assign ERR       = err_q;

endmodule

// File: doc/gpmc_mux_sram.md
GPMC_MUX_SRAM -- requirements
Module: gpmc_mux_sram

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 16, meaning GPMC address/data bus width in bits (legal: 16, 32).
REQ-002 The block SHALL expose parameter ADDR_W, default 10, meaning word-address width; memory depth is 2**ADDR_W words.
REQ-003 The block SHALL expose parameter RD_LAT, default 2, meaning cycles from registered OEN fall to first valid read word (legal 1..7).
REQ-004 Port CLK, input, 1, the only clock; GPMC_CLK drives it, and all GPMC inputs are synchronous to it.
REQ-005 Port RST_N, input, 1: reset is asynchronous and active-low.
REQ-006 Port GPMC_AD, inout, DATA_W, multiplexed address/data bus.
REQ-007 Port GPMC_CSN, input, 1, active-low chip select.
REQ-008 Port GPMC_ADVN, input, 1, active-low address valid.
REQ-009 Port GPMC_OEN, input, 1, active-low output enable (read).
REQ-010 Port GPMC_WEN, input, 1, active-low write enable.
REQ-011 Port GPMC_BEN, input, DATA_W/8, active-low byte enables.
REQ-012 Port GPMC_WAIT, output, 1, high = not ready.
REQ-013 Port ERR, output, 1, sticky protocol-error flag.

Function
REQ-014 All GPMC inputs SHALL be registered once; all decisions below use the registered values.
REQ-015 The FSM SHALL have states IDLE, ADDR, RD_WAIT, RD_BURST, WR_BURST.
- IDLE->ADDR: CSN=0 and ADVN=0.
- ADDR: latch GPMC_AD[ADDR_W-1:0] as word address.
- ADDR->RD_WAIT: OEN=0.
- ADDR->WR_BURST: WEN=0.
- RD_WAIT->RD_BURST: after RD_LAT cycles.
REQ-016 In RD_WAIT, GPMC_WAIT SHALL be 1; in all other states it SHALL be 0.
REQ-017 In RD_BURST, GPMC_AD SHALL drive mem[addr] each cycle OEN=0, with addr incrementing by 1 per cycle (burst).
REQ-018 GPMC_AD SHALL be high-Z unless state=RD_BURST, CSN=0 and OEN=0.
REQ-019 In WR_BURST, every cycle WEN=0 SHALL write GPMC_AD into mem[addr] and then increment addr; WEN=1 cycles SHALL hold addr.
REQ-020 The address SHALL wrap from 2**ADDR_W-1 to 0 in both read and write bursts.
REQ-021 A CSN rise in any state SHALL return the FSM to IDLE within one cycle, aborting the burst; a write already sampled SHALL complete.
REQ-022 A new ADVN=0 while CSN=0 SHALL re-enter ADDR and reload the address.
REQ-023 OEN=0 and WEN=0 in the same registered cycle SHALL perform neither operation, set ERR=1 and go to IDLE.
REQ-024 ERR SHALL clear only on reset.
REQ-025 Read-after-write to the same address in a new transaction SHALL return the written data.

Reset
REQ-026 RST_N=0 SHALL asynchronously force: state=IDLE, GPMC_AD high-Z, GPMC_WAIT=0, ERR=0, addr=0.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 Reset asserted mid-burst SHALL abort the burst with no further writes.

Configuration
REQ-029 With GPMC_BYTE_LANE_EN defined, writes SHALL update only byte lanes whose GPMC_BEN bit is 0.
REQ-030 Without GPMC_BYTE_LANE_EN, GPMC_BEN SHALL be ignored and full words written.

Structure
REQ-031 Package gpmc_pkg SHALL hold the FSM state enum and the RD_LAT maximum constant.
REQ-032 Storage SHALL be sub-module gpmc_sram_mem: single-port, synchronous read, per-byte write enables.

Verification
REQ-033 The bench SHALL cover a single write then read: write 0xA5A5 at address 0x010, then read it back -> GPMC_WAIT high for 2 cycles, then AD=0xA5A5.
REQ-034 The bench SHALL cover a 4-word write burst at 0x3FE (0x1111..0x4444) -> words land at 0x3FE, 0x3FF, 0x000, 0x001 (wrap).
REQ-035 The bench SHALL cover a 4-word read burst from 0x3FE -> 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles.
REQ-036 The bench SHALL cover OEN and WEN low together -> ERR=1, no memory change, ERR held until RST_N=0.
REQ-037 The bench SHALL cover a CSN rise after 2 of 4 burst words -> only 2 words written, AD high-Z, state IDLE.
REQ-038 The bench SHALL cover, with GPMC_BYTE_LANE_EN defined, write 0xBEEF with BEN=2'b10 over 0x1234 -> read returns 0x12EF.
